// File: rtl/wait_event_monitor.sv
// Waits for a rise, fall or level on one named monitored signal, with an optional cycle timeout.
// The command arrives as text: alias, event, level value and timeout.
module wait_event_monitor #(
    parameter int unsigned WAIT_SIZE     = 5,
    parameter int unsigned WAIT_WIDTH    = 32,
    parameter int unsigned TIMEOUT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  string                 i_wait_alias [WAIT_SIZE],
    input  logic [WAIT_WIDTH-1:0] i_wait       [WAIT_SIZE],
    input  logic                  i_wait_sel,
    input  logic                  i_args_valid,
    input  string                 i_args       [5],
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout,
    output logic                  o_unknown
);

    localparam int unsigned IDX_W = (WAIT_SIZE > 1) ? $clog2(WAIT_SIZE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {EVT_RISE, EVT_FALL, EVT_LEVEL, EVT_NONE} evt_t;

    state_t                   r_state;
    evt_t                     r_evt;
    logic                     r_alias_hit;
    logic [IDX_W-1:0]         r_idx;
    logic [WAIT_WIDTH-1:0]    r_value;
    logic [TIMEOUT_WIDTH-1:0] r_timeout;
    logic [TIMEOUT_WIDTH-1:0] r_cnt;
    logic [WAIT_WIDTH-1:0]    r_prev;

    logic                     w_accept;
    logic                     w_alias_hit;
    logic [IDX_W-1:0]         w_alias_idx;
    evt_t                     w_evt;
    logic [WAIT_WIDTH-1:0]    w_value;
    logic [TIMEOUT_WIDTH-1:0] w_timeout;
    logic [WAIT_WIDTH-1:0]    w_cur;
    logic                     w_match;
    logic                     w_expire;

    assign w_accept = i_wait_sel && i_args_valid && (r_state == S_IDLE);

    // Text decode; the descending scan leaves the lowest matching alias index.
    always_comb begin
        w_alias_hit = 1'b0;
        w_alias_idx = '0;
        for (int i = int'(WAIT_SIZE) - 1; i >= 0; i--) begin
            if (i_wait_alias[i] == i_args[1]) begin
                w_alias_hit = 1'b1;
                w_alias_idx = IDX_W'(i);
            end
        end
        if (i_args[2] == "RISE")
            w_evt = EVT_RISE;
        else if (i_args[2] == "FALL")
            w_evt = EVT_FALL;
        else if (i_args[2] == "LEVEL")
            w_evt = EVT_LEVEL;
        else
            w_evt = EVT_NONE;
        w_value   = WAIT_WIDTH'(i_args[3].atoi());
        w_timeout = TIMEOUT_WIDTH'(i_args[4].atoi());
    end

    assign w_cur = i_wait[r_idx];

    always_comb begin
        w_match = 1'b0;
        case (r_evt)
            EVT_RISE:  w_match = !r_prev[0] &&  w_cur[0];
            EVT_FALL:  w_match =  r_prev[0] && !w_cur[0];
            EVT_LEVEL: w_match = (w_cur == r_value);
            default:   w_match = 1'b0;
        endcase
    end

    // Zero timeout never expires.
    assign w_expire = (r_timeout != '0) && (r_cnt == (r_timeout - TIMEOUT_WIDTH'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_evt       <= EVT_RISE;
            r_alias_hit <= 1'b0;
            r_idx       <= '0;
            r_value     <= '0;
            r_timeout   <= '0;
            r_cnt       <= '0;
            r_prev      <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_timeout   <= 1'b0;
            o_unknown   <= 1'b0;
        end else begin
            o_done    <= 1'b0;
            o_timeout <= 1'b0;
            o_unknown <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_alias_hit <= w_alias_hit;
                        r_idx       <= w_alias_idx;
                        r_evt       <= w_evt;
                        r_value     <= w_value;
                        r_timeout   <= w_timeout;
                        o_busy      <= 1'b1;
                        r_state     <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (!r_alias_hit || (r_evt == EVT_NONE)) begin
                        o_done    <= 1'b1;
                        o_unknown <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_prev  <= w_cur;
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_prev <= w_cur;
                    if (r_cnt != '1)
                        r_cnt <= r_cnt + TIMEOUT_WIDTH'(1);
                    // A match takes priority over expiry in the same cycle.
                    if (w_match) begin
                        o_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_expire) begin
                        o_done    <= 1'b1;
                        o_timeout <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wait_event_monitor.sv
// Directed bench for wait_event_monitor; expected completions are queued and
// checked by a monitor that watches o_done.
module tb_wait_event_monitor;

    typedef struct {
        string name;
        int    cyc;
        bit    to;
        bit    unk;
    } exp_t;

    logic        clk;
    logic        rst_n;
    string       alias_s [5];
    logic [31:0] wv      [5];
    logic        sel;
    logic        valid;
    string       args    [5];
    logic        busy, done, tmo, unk;

    int   cyc;
    int   n_vec;
    int   n_bad;
    exp_t sbq [$];

    wait_event_monitor #(.WAIT_SIZE(5), .WAIT_WIDTH(32), .TIMEOUT_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wait_alias (alias_s),
        .i_wait       (wv),
        .i_wait_sel   (sel),
        .i_args_valid (valid),
        .i_args       (args),
        .o_busy       (busy),
        .o_done       (done),
        .o_timeout    (tmo),
        .o_unknown    (unk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Scoreboard monitor: every o_done must pair with a queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_done: got o_done=1 expected no pending command (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk({e.name, "_done_cycle"}, cyc, e.cyc);
                    chk({e.name, "_timeout"}, int'(tmo), int'(e.to));
                    chk({e.name, "_unknown"}, int'(unk), int'(e.unk));
                end
            end else if (tmo || unk) begin
                n_vec++;
                n_bad++;
                $display("FAIL qualifier_without_done: got timeout=%0d unknown=%0d expected 0 (cycle %0d)", tmo, unk, cyc);
            end
        end
    end

    task automatic goto_cycle(input int c);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (cyc < c && g < 2000);
        if (g >= 2000) begin
            n_vec++;
            n_bad++;
            $display("FAIL goto_cycle: got cycle %0d expected %0d", cyc, c);
        end
    endtask

    // Waits for idle, presents a command for one edge, returns the cycle index after accept.
    task automatic issue(input string al, input string ev, input string lvl, input string to,
                         output int acc);
        int g;
        g = 0;
        @(negedge clk);
        while (busy && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) begin
            n_vec++;
            n_bad++;
            $display("FAIL issue_wait_idle: got busy=1 expected 0");
        end
        args[1] = al;
        args[2] = ev;
        args[3] = lvl;
        args[4] = to;
        sel     = 1'b1;
        valid   = 1'b1;
        @(posedge clk);
        #1;
        acc   = cyc;
        sel   = 1'b0;
        valid = 1'b0;
    endtask

    task automatic expect_done(input string nm, input int c, input bit t, input bit u);
        sbq.push_back('{nm, c, t, u});
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int g;
        cyc   = 0;
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        sel   = 1'b0;
        valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            alias_s[i] = $sformatf("I%0d", i);
            wv[i]      = 32'd0;
            args[i]    = "";
        end
        args[0] = "WAIT";
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // RISE on I2, edge seen 10 cycles after accept.
        issue("I2", "RISE", "0", "100", a);
        expect_done("rise_i2", a + 11, 1'b0, 1'b0);
        goto_cycle(a + 5);
        chk("rise_busy_mid", int'(busy), 1);
        goto_cycle(a + 10);
        wv[2] = 32'd1;
        goto_cycle(a + 12);
        chk("rise_busy_after", int'(busy), 0);

        // LEVEL already true at arming matches on the first WAIT cycle.
        wv[1] = 32'd5;
        issue("I1", "LEVEL", "5", "50", a);
        expect_done("level_i1", a + 2, 1'b0, 1'b0);

        // FALL on a signal held high expires after 20 WAIT cycles.
        wv[0] = 32'd1;
        issue("I0", "FALL", "0", "20", a);
        expect_done("fall_i0_timeout", a + 21, 1'b1, 1'b0);

        // Unknown alias and unknown event.
        issue("XX", "RISE", "0", "10", a);
        expect_done("alias_xx", a + 1, 1'b0, 1'b1);
        issue("I3", "EDGE", "0", "10", a);
        expect_done("event_edge", a + 1, 1'b0, 1'b1);

        // Match on the expiry cycle wins; a command while busy is ignored.
        wv[3] = 32'd0;
        issue("I3", "RISE", "0", "5", a);
        expect_done("rise_vs_timeout", a + 6, 1'b0, 1'b0);
        goto_cycle(a + 2);
        args[1] = "I1";
        args[2] = "LEVEL";
        args[3] = "5";
        args[4] = "50";
        sel     = 1'b1;
        valid   = 1'b1;
        @(negedge clk);
        sel   = 1'b0;
        valid = 1'b0;
        goto_cycle(a + 5);
        wv[3] = 32'd1;

        // Same level with a full-width mismatch must time out, not match.
        wv[1] = 32'h0001_0005;
        issue("I1", "LEVEL", "5", "3", a);
        expect_done("level_width", a + 4, 1'b1, 1'b0);

        // Reset mid-WAIT, then a normal RISE.
        wv[4] = 32'd0;
        issue("I4", "RISE", "0", "0", a);
        goto_cycle(a + 4);
        chk("pre_reset_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_timeout", int'(tmo), 0);
        chk("rst_unknown", int'(unk), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_busy", int'(busy), 0);
        issue("I4", "RISE", "0", "1000", a);
        expect_done("rise_after_reset", a + 4, 1'b0, 1'b0);
        goto_cycle(a + 3);
        wv[4] = 32'd1;

        g = 0;
        while (sbq.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
